// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned) that stalls the EX stage while computing.
// Optional DIV_ZERO_SHORTCUT_EN: a zero divisor or dividend skips the iteration and goes straight to sign fix-up.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_en,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               stallE,
    input  logic               flush,
    output logic               div_stall,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*WIDTH-1:0] r_result;
    logic               r_result_valid;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_step_ok;
    logic               w_b_zero;
    logic               w_shortcut;

    function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    assign w_neg_a   = is_signed & a[WIDTH-1];
    assign w_neg_b   = is_signed & b[WIDTH-1];
    assign w_abs_a   = f_neg_if(a, w_neg_a);
    assign w_abs_b   = f_neg_if(b, w_neg_b);
    assign w_b_zero  = (b == {WIDTH{1'b0}});

    // The partial remainder never exceeds the divisor, so one extra bit is enough for the trial subtract.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_step_ok = ~w_diff[WIDTH];

`ifdef DIV_ZERO_SHORTCUT_EN
    assign w_shortcut = w_b_zero | (a == {WIDTH{1'b0}});
`else
    assign w_shortcut = 1'b0;
`endif

    // Stall request to the hazard unit; released in DONE so only other stall sources hold EX.
    always_comb begin
        div_stall = 1'b0;
        if (rst || flush) begin
            div_stall = 1'b0;
        end else begin
            case (r_state)
                IDLE:    div_stall = div_en;
                BUSY:    div_stall = 1'b1;
                SIGN:    div_stall = 1'b1;
                DONE:    div_stall = 1'b0;
                default: div_stall = 1'b0;
            endcase
        end
    end

    // Divider state machine and datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= {CW{1'b0}};
            r_rem          <= {WIDTH{1'b0}};
            r_quo          <= {WIDTH{1'b0}};
            r_div          <= {WIDTH{1'b0}};
            r_sign_q       <= 1'b0;
            r_sign_r       <= 1'b0;
            r_result       <= {(2*WIDTH){1'b0}};
            r_result_valid <= 1'b0;
        end else if (flush) begin
            r_state        <= IDLE;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (div_en) begin
                        r_sign_q <= w_neg_a ^ w_neg_b;
                        r_sign_r <= w_neg_a;
                        r_div    <= w_abs_b;
                        r_cnt    <= CW'(WIDTH);
                        if (w_shortcut) begin
                            r_rem   <= w_b_zero ? w_abs_a : {WIDTH{1'b0}};
                            r_quo   <= w_b_zero ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                            r_state <= SIGN;
                        end else begin
                            r_rem   <= {WIDTH{1'b0}};
                            r_quo   <= w_abs_a;
                            r_state <= BUSY;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (w_step_ok) begin
                        r_rem <= w_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == {{(CW-1){1'b0}}, 1'b1}) begin
                        r_state <= SIGN;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                SIGN: begin
                    r_result       <= {f_neg_if(r_rem, r_sign_r), f_neg_if(r_quo, r_sign_q)};
                    r_result_valid <= 1'b1;
                    r_state        <= DONE;
                end
                DONE: begin
                    if (!stallE) begin
                        r_result_valid <= 1'b0;
                        r_state        <= IDLE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_result_valid <= 1'b0;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases with literal expectations plus randomized divides
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_div_iter;
    localparam int W = 32;
`ifdef DIV_ZERO_SHORTCUT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_en = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        stallE = 1'b0;
    logic        flush = 1'b0;
    logic        div_stall;
    logic [63:0] result;
    logic        result_valid;

    int errors = 0;
    int checks = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .div_en(div_en), .is_signed(is_signed),
        .a(a), .b(b), .stallE(stallE), .flush(flush),
        .div_stall(div_stall), .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference quotient/remainder from plain integer arithmetic on magnitudes.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input bit s);
        logic [31:0] ux, uy, q, r;
        ux = (s && x[31]) ? (32'd0 - x) : x;
        uy = (s && y[31]) ? (32'd0 - y) : y;
        if (uy == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = ux;
        end else begin
            q = ux / uy;
            r = ux % uy;
        end
        if (s && (x[31] ^ y[31])) q = 32'd0 - q;
        if (s && x[31]) r = 32'd0 - r;
        return {r, q};
    endfunction

    // Model: m_left = stall cycles still owed after the accept cycle; m_done = result on display.
    int          m_left;
    bit          m_done;
    logic [63:0] m_res;
    logic [63:0] m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 64'd0;
            m_pend <= 64'd0;
        end else if (flush) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            if (!stallE) m_done <= 1'b0;
        end else if (m_left > 0) begin
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
            m_left <= m_left - 1;
        end else if (div_en) begin
            m_left <= (SC && (a == 32'd0 || b == 32'd0)) ? 1 : W + 1;
            m_pend <= ref_div(a, b, is_signed);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_stall", {63'd0, div_stall}, 64'd0);
            check("rst_valid", {63'd0, result_valid}, 64'd0);
            check("rst_result", result, 64'd0);
        end else begin
            check("model_stall", {63'd0, div_stall}, {63'd0, (!flush && (m_left > 0 || (!m_done && div_en)))});
            check("model_valid", {63'd0, result_valid}, {63'd0, m_done});
            check("model_result", result, m_res);
        end
    end

    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input bit s, input int hold,
                           input int flush_cyc, input bit lit, input logic [63:0] exp, input int exp_n);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        @(posedge clk); #2;
        a = x; b = y; is_signed = s; div_en = 1'b1; stallE = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (i == flush_cyc) flush = 1'b1;
            @(negedge clk);
            if (flush) begin
                if (lit) check("flush_stall", {63'd0, div_stall}, 64'd0);
                @(posedge clk); #2;
                flush = 1'b0; div_en = 1'b0; stallE = 1'b0;
                @(negedge clk);
                if (lit) begin
                    check("flush_valid", {63'd0, result_valid}, 64'd0);
                    check("flush_idle_stall", {63'd0, div_stall}, 64'd0);
                end
                return;
            end
            if (div_stall) n++;
            if (result_valid) seen = 1'b1;
            else begin
                @(posedge clk); #2;
                stallE = 1'b1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: result_valid never rose for a=%h b=%h", x, y);
            div_en = 1'b0; stallE = 1'b0;
            return;
        end
        if (lit) begin
            check("result", result, exp);
            check("stall_cycles", 64'(n), 64'(exp_n));
        end
        repeat (hold) begin
            @(posedge clk); #2;
            @(negedge clk);
            if (lit) begin
                check("hold_valid", {63'd0, result_valid}, 64'd1);
                check("hold_stall", {63'd0, div_stall}, 64'd0);
                check("hold_result", result, exp);
            end
        end
        @(posedge clk); #2;
        stallE = 1'b0;
        @(posedge clk); #2;
        div_en = 1'b0;
        @(negedge clk);
        if (lit) check("after_done_valid", {63'd0, result_valid}, 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", {63'd0, div_stall}, 64'd0);
        check("reset_valid", {63'd0, result_valid}, 64'd0);
        check("reset_result", result, 64'd0);

        run_div(32'd100, 32'd7, 1'b0, 0, -1, 1'b1, {32'h00000002, 32'h0000000E}, 34);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, -1, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, -1, 1'b1, {32'h00000000, 32'h80000000}, 34);
        run_div(32'h12345678, 32'd0, 1'b0, 0, -1, 1'b1, {32'h12345678, 32'hFFFFFFFF}, SC ? 2 : 34);
        run_div(32'd1000, 32'd3, 1'b0, 0, 10, 1'b1, 64'd0, 34);
        run_div(32'd9, 32'd3, 1'b0, 0, -1, 1'b1, {32'h00000000, 32'h00000003}, 34);
        run_div(32'd50, 32'd5, 1'b0, 3, -1, 1'b1, {32'h00000000, 32'h0000000A}, 34);

        // Asynchronous reset in the middle of an iteration.
        @(posedge clk); #2;
        a = 32'd1000; b = 32'd3; is_signed = 1'b0; div_en = 1'b1; stallE = 1'b1;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_stall", {63'd0, div_stall}, 64'd0);
        check("async_rst_valid", {63'd0, result_valid}, 64'd0);
        check("async_rst_result", result, 64'd0);
        div_en = 1'b0; stallE = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        run_div(32'hFFFFFF9C, 32'd7, 1'b1, 0, -1, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 34);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] x, y;
            int          fc;
            case ($urandom_range(0, 5))
                0:       x = 32'd0;
                1:       x = 32'h80000000;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = 32'hFFFFFFFF;
                2:       y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            fc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 36)) : -1;
            run_div(x, y, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), fc, 1'b0, 64'd0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
